wb_data_ram_slave: RTL and testbench
====================================

WB_DATA_RAM_SLAVE -- requirements
Module: wb_data_ram_slave

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH_LOG2, default 10, log2 of the word count.
- WAIT_STATES, default 1, legal 0..15, wait cycles inserted before the response.
- BASE_ADDR, default 32'h0000_0000, byte base address of the RAM window.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  transfer strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte-lane enables; bit n selects bits 8n+7:8n.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- busy_o  out  1  high while in the WAIT or RESP state.

Function
REQ-003 The block SHALL be a Wishbone B4 classic slave with three states: IDLE, WAIT and RESP.
REQ-004 In IDLE, when wb_cyc_i & wb_stb_i is high at a clock edge, the block SHALL latch adr, we, sel and dat, and move to:
- RESP if WAIT_STATES=0;
- otherwise WAIT, with the wait counter loaded to WAIT_STATES-1.
REQ-005 In WAIT, the counter SHALL decrement each cycle; the block SHALL enter RESP on the edge where the counter is 0.
REQ-006 In WAIT, if wb_cyc_i is low at a clock edge, the block SHALL abort to IDLE with no memory write and no ack or err.
REQ-007 Bus inputs SHALL be ignored outside IDLE; all decisions SHALL use the latched values.
REQ-008 wb_ack_o or wb_err_o SHALL be registered, and high for exactly the one cycle spent in RESP; RESP SHALL always return to IDLE.
REQ-009 Latency SHALL be WAIT_STATES+1 cycles from the request-sampling edge to the ack cycle, so each transfer occupies WAIT_STATES+2 cycles.
REQ-010 A request SHALL be an error when:
- latched adr[1:0] != 0; or
- adr < BASE_ADDR; or
- ((adr-BASE_ADDR)>>2) >= 2**DEPTH_LOG2.
REQ-011 An error request SHALL assert wb_err_o instead of wb_ack_o, perform no write, and return wb_dat_o = 0.
REQ-012 A valid write SHALL commit the selected byte lanes on the RESP-entry edge; unselected lanes SHALL be unchanged.
REQ-013 A write with sel=4'b0000 SHALL be acked with no change to memory.
REQ-014 A valid read SHALL drive the full 32-bit word, regardless of sel, on wb_dat_o during the ack cycle.
REQ-015 wb_dat_o SHALL be 0 in every cycle without a read ack.
REQ-016 If wb_cyc_i drops during RESP, the ack SHALL still pulse, and an already committed write SHALL stand.
REQ-017 A request held on the bus across the ack cycle SHALL be sampled as a new transfer in the following IDLE cycle.
REQ-018 Word index arithmetic SHALL use 32-bit unsigned subtraction, then drop adr[1:0]; the upper bound SHALL not wrap.

Reset
REQ-019 Assertion of rst (low) SHALL immediately force:
- state IDLE;
- counter 0;
- wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0.
REQ-020 Reset mid-transfer SHALL abandon the transfer; a write SHALL not commit unless its RESP-entry edge preceded the reset assertion.
REQ-021 Memory contents SHALL not be reset and are undefined after power-up.
REQ-022 Deassertion of rst SHALL take effect on the first rising clk edge after release.

Structure
REQ-023 The state encoding, the Wishbone data/address/select widths and the wait-counter width SHALL be defined in the shared definitions file used across the core.
REQ-024 The memory array SHALL be a sub-module, wb_ram_core: single-port, DEPTH_LOG2-bit word address, per-byte write enables, combinational read.

Verification
REQ-025 The bench SHALL cover these scenarios:
- WAIT_STATES=1: write 32'hDEAD_BEEF to 0x10 with sel=4'hF, then read 0x10 -> ack 2 cycles after sampling both times; read returns 32'hDEAD_BEEF; busy_o high for 2 cycles.
- Byte write of 32'h0000_00AA to 0x10 with sel=4'b0001 over 32'hDEAD_BEEF, then read -> 32'hDEAD_BEAA.
- Read of 0x12, and read of 0x1000 with DEPTH_LOG2=10 -> wb_err_o single pulse, wb_ack_o 0, wb_dat_o 0, memory unchanged.
- WAIT_STATES=3: wb_cyc_i dropped in the second wait cycle of a write of 32'h1234_5678 to 0x20 -> no ack; a later read of 0x20 returns the prior value.
- WAIT_STATES=0: wb_stb_i held high for 6 cycles on reads of 0x0 -> acks in cycles 1, 3 and 5, never on consecutive cycles.
- rst pulsed low during WAIT of a write to 0x30 -> outputs 0 immediately; after release, a read of 0x30 returns the old value.

Source files
------------

// File: rtl/wb_data_ram_slave_pkg.sv
// Shared definitions for the Wishbone data RAM slave: bus widths, the
// wait-counter width, the FSM encoding and the address-error decode.
package wb_data_ram_slave_pkg;

  localparam int WB_DW  = 32;
  localparam int WB_AW  = 32;
  localparam int WB_SW  = WB_DW / 8;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // An access is illegal when it is misaligned, below the window, or beyond
  // the last word. The bound is compared on WB_AW+1 bits so it never wraps.
  function automatic logic addr_err(input logic [WB_AW-1:0] adr,
                                    input logic [WB_AW-1:0] base,
                                    input int unsigned      depth_log2);
    logic [WB_AW-1:0] off;
    logic [WB_AW:0]   widx;
    logic [WB_AW:0]   limit;
    off   = adr - base;
    widx  = {3'b000, off[WB_AW-1:2]};
    limit = {{WB_AW{1'b0}}, 1'b1} << depth_log2;
    addr_err = (adr[1:0] != 2'b00) || (adr < base) || (widx >= limit);
  endfunction

endpackage

// File: rtl/wb_data_ram_slave_ram_core.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are intentionally not reset.
module wb_ram_core
  import wb_data_ram_slave_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [WB_SW-1:0] be_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WB_DW-1:0] wdata_i,
  output logic [WB_DW-1:0] rdata_o
);

  logic [WB_DW-1:0] mem_q [0:(1<<AW)-1];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WB_SW; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone B4 classic slave in front of a word RAM, with a programmable
// number of wait states before each single-cycle ack/err response.
module wb_data_ram_slave
  import wb_data_ram_slave_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [WB_AW-1:0] wb_adr_i,
  input  logic [WB_SW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             busy_o
);

  localparam logic [WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? {WCNT_W{1'b0}} : WCNT_W'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [WB_AW-1:0]  adr_q, adr_d;
  logic              we_q, we_d;
  logic [WB_SW-1:0]  sel_q, sel_d;
  logic [WB_DW-1:0]  dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WB_DW-1:0]  rdat_q, rdat_d;
  logic              busy_q, busy_d;

  logic [WB_AW-1:0]      op_adr_s;
  logic                  op_we_s;
  logic [WB_SW-1:0]      op_sel_s;
  logic [WB_DW-1:0]      op_dat_s;
  logic                  op_err_s;
  logic [WB_AW-1:0]      word_off_s;
  logic [DEPTH_LOG2-1:0] ram_addr_s;
  logic [WB_DW-1:0]      ram_rdata_s;
  logic                  enter_resp_s;
  logic                  mem_we_s;

  // Operand select: live bus values on the sampling edge (needed when there
  // are no wait states), latched values for the rest of the transfer.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_adr_s = wb_adr_i;
      op_we_s  = wb_we_i;
      op_sel_s = wb_sel_i;
      op_dat_s = wb_dat_i;
    end else begin
      op_adr_s = adr_q;
      op_we_s  = we_q;
      op_sel_s = sel_q;
      op_dat_s = dat_q;
    end
  end

  assign op_err_s   = addr_err(op_adr_s, BASE_ADDR, DEPTH_LOG2);
  assign word_off_s = op_adr_s - BASE_ADDR;
  assign ram_addr_s = DEPTH_LOG2'(word_off_s >> 2);
  // Gating with rst keeps a held request from writing while in reset.
  assign mem_we_s   = enter_resp_s & op_we_s & ~op_err_s & rst;

  // Next-state, wait counter, request latch and registered response values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdat_d       = {WB_DW{1'b0}};
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d = wb_adr_i;
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          if (WAIT_STATES == 0) begin
            state_d      = ST_RESP;
            cnt_d        = {WCNT_W{1'b0}};
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = {WCNT_W{1'b0}};
        end else if (cnt_q == {WCNT_W{1'b0}}) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - WCNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {WCNT_W{1'b0}};
      end
    endcase
    if (enter_resp_s) begin
      ack_d  = ~op_err_s;
      err_d  = op_err_s;
      rdat_d = (!op_we_s && !op_err_s) ? ram_rdata_s : {WB_DW{1'b0}};
    end else begin
      rdat_d = {WB_DW{1'b0}};
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces an idle, silent bus interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {WCNT_W{1'b0}};
      adr_q   <= {WB_AW{1'b0}};
      we_q    <= 1'b0;
      sel_q   <= {WB_SW{1'b0}};
      dat_q   <= {WB_DW{1'b0}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= {WB_DW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      busy_q  <= busy_d;
    end
  end

  wb_ram_core #(.AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (mem_we_s),
    .be_i    (op_sel_s),
    .addr_i  (ram_addr_s),
    .wdata_i (op_dat_s),
    .rdata_o (ram_rdata_s)
  );

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Directed bench for wb_data_ram_slave: three instances with 1, 3 and 0
// wait states, a vector table of single transfers, and hand-written
// sequences for abort, back-to-back and mid-transfer reset behaviour.
module tb_wb_data_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0]       cyc, stb, we;
  logic [2:0][31:0] adr, dati;
  logic [2:0][3:0]  sel;

  logic [31:0] dato0, dato1, dato2;
  logic        ack0, ack1, ack2, err0, err1, err2, busy0, busy1, busy2;
  logic [2:0]       ack_v, err_v, busy_v;
  logic [2:0][31:0] dato_v;
  assign ack_v  = {ack2, ack1, ack0};
  assign err_v  = {err2, err1, err0};
  assign busy_v = {busy2, busy1, busy0};
  assign dato_v = {dato2, dato1, dato0};

  int errors = 0;
  int checks = 0;

  wb_data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dati[0]), .wb_dat_o(dato0),
    .wb_ack_o(ack0), .wb_err_o(err0), .busy_o(busy0));

  wb_data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dati[1]), .wb_dat_o(dato1),
    .wb_ack_o(ack1), .wb_err_o(err1), .busy_o(busy1));

  wb_data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_adr_i(adr[2]), .wb_sel_i(sel[2]), .wb_dat_i(dati[2]), .wb_dat_o(dato2),
    .wb_ack_o(ack2), .wb_err_o(err2), .busy_o(busy2));

  typedef struct {
    int          inst;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer, held until ack/err (bounded); reports latency and data.
  task automatic do_req(input int i, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output int lat, output logic got_err, output logic [31:0] rd,
                        output int busy_cnt, output logic bad_dat);
    lat = 0; got_err = 1'b0; rd = 32'h0; busy_cnt = 0; bad_dat = 1'b0;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dati[i] = d;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy_v[i]) busy_cnt++;
      if (ack_v[i] || err_v[i]) begin
        lat = k; got_err = err_v[i]; rd = dato_v[i];
        break;
      end else if (dato_v[i] != 32'h0) begin
        bad_dat = 1'b1;
      end
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat, bc;
    logic ge, bd;
    logic [31:0] rd;
    do_req(v.inst, v.we, v.adr, v.sel, v.dat, lat, ge, rd, bc, bd);
    chk($sformatf("v%0d latency", n), lat, ws_of(v.inst) + 1);
    chk($sformatf("v%0d err", n), ge, v.exp_err);
    chk($sformatf("v%0d rdata", n), rd, v.exp_rd);
    chk($sformatf("v%0d busy_cycles", n), bc, ws_of(v.inst) + 1);
    chk($sformatf("v%0d dat_before_ack", n), bd, 1'b0);
    @(posedge clk); #1;
    chk($sformatf("v%0d after_ack ack/err/busy", n),
        {ack_v[v.inst], err_v[v.inst], busy_v[v.inst]}, 3'b000);
    chk($sformatf("v%0d after_ack dat", n), dato_v[v.inst], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic saw, bad;
    logic [6:0] ack_pat;

    cyc = '0; stb = '0; we = '0; adr = '0; sel = '0; dati = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // inst, we, adr, sel, dat, exp_err, exp_rd
    tbl.push_back('{0, 1'b1, 32'h10,   4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1'b1, 32'h10,   4'h1, 32'h0000_00AA, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,         1'b0, 32'hDEAD_BEAA});
    tbl.push_back('{0, 1'b0, 32'h12,   4'hF, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h1000, 4'hF, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h12,   4'hF, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,         1'b0, 32'hDEAD_BEAA});
    tbl.push_back('{0, 1'b1, 32'h14,   4'hF, 32'h1122_3344, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h14,   4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h14,   4'hF, 32'h0,         1'b0, 32'h1122_3344});
    tbl.push_back('{0, 1'b1, 32'h14,   4'h6, 32'hAABB_CCDD, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h14,   4'hF, 32'h0,         1'b0, 32'h11BB_CC44});
    tbl.push_back('{0, 1'b1, 32'hFFC,  4'hF, 32'hCAFE_F00D, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'hFFC,  4'hF, 32'h0,         1'b0, 32'hCAFE_F00D});
    tbl.push_back('{0, 1'b1, 32'h1000, 4'hF, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'h0, 32'h0,         1'b0, 32'hDEAD_BEAA});
    tbl.push_back('{1, 1'b1, 32'h20,   4'hF, 32'hA5A5_0001, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 32'h30,   4'hF, 32'h5555_AAAA, 1'b0, 32'h0});
    tbl.push_back('{2, 1'b1, 32'h0,    4'hF, 32'h0BAD_CAFE, 1'b0, 32'h0});
    tbl.push_back('{2, 1'b0, 32'h0,    4'hF, 32'h0,         1'b0, 32'h0BAD_CAFE});

    // Reset state of every instance while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset inst%0d ack/err/busy", i), {ack_v[i], err_v[i], busy_v[i]}, 3'b000);
      chk($sformatf("reset inst%0d dat", i), dato_v[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < tbl.size(); n++) begin
      run_vec(tbl[n], n);
    end

    // Abort: cyc dropped in the second wait cycle of a 3-wait-state write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; sel[1] = 4'hF;
    dati[1] = 32'h1234_5678;
    @(posedge clk); #1;
    chk("abort wait1 busy", busy_v[1], 1'b1);
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack_v[1] || err_v[1]) saw = 1'b1;
    end
    chk("abort no ack/err", saw, 1'b0);
    chk("abort back idle", busy_v[1], 1'b0);
    v = '{1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hA5A5_0001};
    run_vec(v, 100);

    // Zero wait states, request held six cycles: acks on cycles 1, 3, 5.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h0; sel[2] = 4'hF;
    ack_pat = 7'h0; bad = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin cyc[2] = 1'b0; stb[2] = 1'b0; end
      ack_pat[c] = ack_v[2];
      if (dato_v[2] != (ack_v[2] ? 32'h0BAD_CAFE : 32'h0)) bad = 1'b1;
    end
    @(posedge clk); #1;
    ack_pat[0] = ack_v[2];
    chk("b2b ack pattern", ack_pat, 7'b0101010);
    chk("b2b data", bad, 1'b0);

    // Reset pulsed during the wait phase of a write to 0x30.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; sel[1] = 4'hF;
    dati[1] = 32'hFFFF_0000;
    @(posedge clk); #1;
    chk("rst-mid busy before", busy_v[1], 1'b1);
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    #1;
    chk("rst-mid immediate ack/err/busy", {ack_v[1], err_v[1], busy_v[1]}, 3'b000);
    chk("rst-mid immediate dat", dato_v[1], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h5555_AAAA};
    run_vec(v, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
